// File: rtl/adc_uart_framer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_uart_framer
//  Description : Packs one 4-channel 10-bit ADC sample set into a 7-byte
//                frame and sends it as 8N1 UART with one pending-set slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_uart_framer #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       sample_valid,
    input  logic [9:0] ch1,
    input  logic [9:0] ch2,
    input  logic [9:0] ch3,
    input  logic [9:0] ch4,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] overrun_count
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_START     = 2'd1;
    localparam logic [1:0]  c_DATA      = 2'd2;
    localparam logic [1:0]  c_STOP      = 2'd3;
    localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  c_LAST_BYTE = 3'd6;

    logic [1:0]  r_state;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_cnt;
    logic [2:0]  r_byte_idx;
    logic [55:0] r_frame;
    logic        r_slot_full;
    logic [39:0] r_slot_data;
    logic [7:0]  r_overrun;
    logic        r_tx;
    logic        r_busy;

    logic [1:0]  w_state_next;
    logic [15:0] w_baud_next;
    logic [2:0]  w_bit_next;
    logic [2:0]  w_byte_next;
    logic [55:0] w_frame_next;
    logic        w_slot_full_next;
    logic [39:0] w_slot_data_next;
    logic [7:0]  w_overrun_next;
    logic        w_tx_next;
    logic        w_frame_done;
    logic        w_bit_end;
    logic        w_load;
    logic        w_slot_free;
    logic [7:0]  w_chk;
    logic [55:0] w_packed;
    logic [7:0]  w_cur_byte;

    assign w_bit_end   = (r_baud_cnt == c_BIT_LAST);
    assign w_load      = (r_state == c_IDLE) && r_slot_full;
    // The slot counts as free in the cycle IDLE drains it into the frame.
    assign w_slot_free = !r_slot_full || w_load;

    assign w_chk    = r_slot_data[39:32] ^ r_slot_data[31:24] ^ r_slot_data[23:16]
                    ^ r_slot_data[15:8]  ^ r_slot_data[7:0];
    // Byte 0 sits in the low byte; each finished byte shifts the frame right.
    assign w_packed = {w_chk, r_slot_data[7:0], r_slot_data[15:8], r_slot_data[23:16],
                       r_slot_data[31:24], r_slot_data[39:32], SYNC_BYTE};

    always_comb begin
        w_slot_full_next = r_slot_full;
        w_slot_data_next = r_slot_data;
        w_overrun_next   = r_overrun;
        if (w_load) begin
            w_slot_full_next = 1'b0;
        end
        if (en && sample_valid) begin
            if (w_slot_free) begin
                w_slot_full_next = 1'b1;
                w_slot_data_next = {ch1, ch2, ch3, ch4};
            end else if (r_overrun != 8'hFF) begin
                w_overrun_next = r_overrun + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt + 16'd1;
        w_bit_next   = r_bit_cnt;
        w_byte_next  = r_byte_idx;
        w_frame_next = r_frame;
        w_frame_done = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_baud_next = 16'd0;
                if (r_slot_full) begin
                    w_state_next = c_START;
                    w_byte_next  = 3'd0;
                    w_frame_next = w_packed;
                end
            end
            c_START: begin
                if (w_bit_end) begin
                    w_baud_next  = 16'd0;
                    w_bit_next   = 3'd0;
                    w_state_next = c_DATA;
                end
            end
            c_DATA: begin
                if (w_bit_end) begin
                    w_baud_next = 16'd0;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = c_STOP;
                    end else begin
                        w_bit_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            c_STOP: begin
                if (w_bit_end) begin
                    w_baud_next = 16'd0;
                    if (r_byte_idx == c_LAST_BYTE) begin
                        w_state_next = c_IDLE;
                        w_frame_done = 1'b1;
                    end else begin
                        w_state_next = c_START;
                        w_byte_next  = r_byte_idx + 3'd1;
                        w_frame_next = {8'h00, r_frame[55:8]};
                    end
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // tx is registered from the next state so the line changes with the state.
    assign w_cur_byte = w_frame_next[7:0];
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            c_START: w_tx_next = 1'b0;
            c_DATA:  w_tx_next = w_cur_byte[w_bit_next];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_baud_cnt  <= 16'd0;
            r_bit_cnt   <= 3'd0;
            r_byte_idx  <= 3'd0;
            r_frame     <= 56'd0;
            r_slot_full <= 1'b0;
            r_slot_data <= 40'd0;
            r_overrun   <= 8'd0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_baud_cnt  <= w_baud_next;
            r_bit_cnt   <= w_bit_next;
            r_byte_idx  <= w_byte_next;
            r_frame     <= w_frame_next;
            r_slot_full <= w_slot_full_next;
            r_slot_data <= w_slot_data_next;
            r_overrun   <= w_overrun_next;
            r_tx        <= w_tx_next;
            r_busy      <= (w_state_next != c_IDLE) || w_slot_full_next;
        end
    end

    assign tx            = r_tx;
    assign busy          = r_busy;
    assign frame_done    = w_frame_done;
    assign overrun_count = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adc_uart_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_uart_framer
//  Description : Directed self-checking bench for adc_uart_framer, with a
//                UART decoder sampling each bit mid-period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_uart_framer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       sample_valid = 1'b0;
    logic [9:0] ch1 = '0, ch2 = '0, ch3 = '0, ch4 = '0;
    logic       tx, busy, frame_done;
    logic [7:0] overrun_count;

    int checks = 0;
    int errors = 0;

    adc_uart_framer #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .en(en), .sample_valid(sample_valid),
        .ch1(ch1), .ch2(ch2), .ch3(ch3), .ch4(ch4),
        .tx(tx), .busy(busy), .frame_done(frame_done), .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; inputs are scrambled afterwards to prove capture froze them.
    task automatic strobe(input logic [9:0] a, input logic [9:0] b,
                          input logic [9:0] c, input logic [9:0] d);
        ch1 = a; ch2 = b; ch3 = c; ch4 = d;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        ch1 = ~a; ch2 = ~b; ch3 = ~c; ch4 = ~d;
    endtask

    task automatic start_frame(input string tag, input logic [9:0] a, input logic [9:0] b,
                               input logic [9:0] c, input logic [9:0] d);
        strobe(a, b, c, d);
        check({tag, "_lat1_tx"}, 32'(tx), 32'd1);
        tick();
        check({tag, "_lat2_tx"}, 32'(tx), 32'd0);
    endtask

    // Entered on the first cycle of the start bit; leaves on the frame's last cycle.
    task automatic run_frame(input string tag, input logic [55:0] exp);
        logic [7:0] got [7];
        int framing_err = 0;
        int fd_cnt = 0;
        int fd_last = 0;
        for (int k = 0; k < 7; k++) got[k] = 8'h00;
        for (int c = 0; c < 70 * CPB; c++) begin
            int bitpos, by, j;
            if (c > 0) tick();
            bitpos = c / CPB;
            by = bitpos / 10;
            j = bitpos % 10;
            if ((c % CPB) == CPB / 2) begin
                if (j == 0) begin
                    if (tx !== 1'b0) framing_err++;
                end else if (j == 9) begin
                    if (tx !== 1'b1) framing_err++;
                end else begin
                    got[by][j-1] = tx;
                end
            end
            if (frame_done === 1'b1) begin
                fd_cnt++;
                if (c == 70 * CPB - 1) fd_last = 1;
            end
        end
        for (int k = 0; k < 7; k++)
            check($sformatf("%s_byte%0d", tag, k), 32'(got[k]), 32'(exp[8*k +: 8]));
        check({tag, "_framing"}, 32'(framing_err), 32'd0);
        check({tag, "_done_count"}, 32'(fd_cnt), 32'd1);
        check({tag, "_done_last_cycle"}, 32'(fd_last), 32'd1);
    endtask

    task automatic quiet(input string tag, input int n, input logic exp_busy);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx !== 1'b1 || frame_done !== 1'b0 || busy !== exp_busy) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // Expected frames, byte 0 in the low byte
    localparam logic [55:0] c_FRAME_T2 = {8'hC6, 8'hAA, 8'h56, 8'h05, 8'hC0, 8'hFF, 8'hA5};
    localparam logic [55:0] c_FRAME_A  = {8'h68, 8'h04, 8'h0C, 8'h20, 8'h40, 8'h00, 8'hA5};
    localparam logic [55:0] c_FRAME_B  = {8'h9C, 8'h00, 8'hFC, 8'h5F, 8'h95, 8'hAA, 8'hA5};
    localparam logic [55:0] c_FRAME_6  = {8'hA6, 8'hC3, 8'hAB, 8'hC2, 8'h30, 8'h3C, 8'hA5};

    initial begin
        // 1: reset then idle
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_after_reset", {tx, busy, frame_done, overrun_count},
                  {1'b1, 1'b0, 1'b0, 8'h00});
        end

        // 2: single frame with the reference pattern
        start_frame("t2", 10'h3FF, 10'h000, 10'h155, 10'h2AA);
        run_frame("t2", c_FRAME_T2);
        tick();
        check("t2_busy_after", 32'(busy), 32'd0);

        // 3: A in flight, B pending, C dropped
        start_frame("t3A", 10'h001, 10'h002, 10'h003, 10'h004);
        fork
            run_frame("t3A", c_FRAME_A);
            begin
                repeat (90) tick();
                strobe(10'h2AA, 10'h155, 10'h3FF, 10'h000);
                repeat (79) tick();
                strobe(10'h111, 10'h111, 10'h111, 10'h111);
            end
        join
        tick();
        check("t3_gap_tx", 32'(tx), 32'd1);
        check("t3_gap_busy", 32'(busy), 32'd1);
        tick();
        check("t3B_start_tx", 32'(tx), 32'd0);
        run_frame("t3B", c_FRAME_B);
        tick();
        check("t3_busy_after", 32'(busy), 32'd0);
        check("t3_overrun", 32'(overrun_count), 32'd1);
        quiet("t3_no_frame_C", 100, 1'b0);

        // 4: continuous strobing saturates the overrun counter
        ch1 = 10'h0AB; ch2 = 10'h0CD; ch3 = 10'h0EF; ch4 = 10'h012;
        sample_valid = 1'b1;
        tick();
        tick();
        check("t4_capture_on_load", 32'(overrun_count), 32'd1);
        repeat (300) tick();
        check("t4_saturated", 32'(overrun_count), 32'd255);
        repeat (5) tick();
        check("t4_stays_255", 32'(overrun_count), 32'd255);
        sample_valid = 1'b0;
        wait_idle("t4_drain", 2000);

        // 5: reset in byte 3 with the slot full
        start_frame("t5", 10'h001, 10'h002, 10'h003, 10'h004);
        repeat (100) tick();
        strobe(10'h2AA, 10'h155, 10'h3FF, 10'h000);
        repeat (29) tick();
        check("t5_busy_before_rst", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("t5_tx_after_rst", 32'(tx), 32'd1);
        tick();
        reset = 1'b0;
        check("t5_overrun_cleared", 32'(overrun_count), 32'd0);
        check("t5_busy_cleared", 32'(busy), 32'd0);
        quiet("t5_no_activity", 400, 1'b0);

        // 6: en low ignores strobes, then one real frame
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe(10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF);
            repeat (5) tick();
        end
        quiet("t6_en_low_quiet", 300, 1'b0);
        check("t6_overrun_unchanged", 32'(overrun_count), 32'd0);
        en = 1'b1;
        start_frame("t6", 10'h0F0, 10'h30C, 10'h0AA, 10'h3C3);
        run_frame("t6", c_FRAME_6);
        tick();
        check("t6_busy_after", 32'(busy), 32'd0);
        quiet("t6_single_frame", 300, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
